hex_keypad_entry: RTL

- Input-side counterpart of the TDM 7-segment display driver.
- Scans a 4x4 hex keypad matrix (PmodKYPD style) by time-multiplexing one-cold column drives.
- Debounces presses and shifts each accepted hex digit into an N-bit value register.
- The value register drives the display driver's BCD/hex input directly, so typed digits scroll in from the least-significant display position.

---
 rtl/keypad_pkg.sv | 70 +++++++
 rtl/keypad_debouncer.sv | 123 ++++++++++++
 rtl/hex_keypad_entry.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the hex keypad entry block: FSM and
// frame-classification enums, the 4x4 key map and row-bit helpers.
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FR_NONE   = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } frame_t;

    // Hex code printed on the key at (row, col) of a PmodKYPD-style pad.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'h0;
            4'd13:   code = 4'hF;
            4'd14:   code = 4'hE;
            4'd15:   code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Number of active-low (pressed) row lines, 0..4.
    function automatic logic [2:0] low_count(input logic [3:0] rows_n);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            cnt = cnt + {2'b00, ~rows_n[i]};
        end
        return cnt;
    endfunction

    // Index of the lowest-numbered low row line; only meaningful when one is low.
    function automatic logic [1:0] first_low(input logic [3:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows_n[i]) begin
                idx = 2'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// Frame-rate debounce FSM: turns a stream of per-frame classifications into
// a single accept decision per key press, with no auto-repeat. The accept
// decision is produced in the frame-end cycle and registered by the parent.
module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_valid,
    input  frame_t     frame_kind,
    input  logic [3:0] frame_code,
    output logic       accept,
    output logic [3:0] accept_code
);

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE);

    state_t     state_r;
    state_t     state_s;
    logic [3:0] cand_r;
    logic [3:0] cand_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_s;
    logic       accept_s;

    // Next-state and accept decision, evaluated only on frame-end cycles.
    always_comb begin
        state_s  = state_r;
        cand_s   = cand_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        if (frame_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (frame_kind == FR_SINGLE) begin
                        cand_s = frame_code;
                        if (DEBOUNCE == 1) begin
                            accept_s = 1'b1;
                            state_s  = ST_HELD;
                            cnt_s    = 4'd0;
                        end else begin
                            state_s = ST_DEBOUNCE;
                            cnt_s   = 4'd1;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (frame_kind == FR_SINGLE) begin
                        if (frame_code == cand_r) begin
                            if ((cnt_r + 4'd1) == DB_LAST) begin
                                accept_s = 1'b1;
                                state_s  = ST_HELD;
                                cnt_s    = 4'd0;
                            end else begin
                                cnt_s = cnt_r + 4'd1;
                            end
                        end else begin
                            cand_s = frame_code;
                            cnt_s  = 4'd1;
                        end
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = 4'd0;
                    end
                end
                ST_HELD: begin
                    if (frame_kind == FR_NONE) begin
                        if (DEBOUNCE == 1) begin
                            state_s = ST_IDLE;
                            cnt_s   = 4'd0;
                        end else begin
                            state_s = ST_RELEASE;
                            cnt_s   = 4'd1;
                        end
                    end else begin
                        state_s = ST_HELD;
                    end
                end
                ST_RELEASE: begin
                    if (frame_kind == FR_NONE) begin
                        if ((cnt_r + 4'd1) == DB_LAST) begin
                            state_s = ST_IDLE;
                            cnt_s   = 4'd0;
                        end else begin
                            cnt_s = cnt_r + 4'd1;
                        end
                    end else begin
                        state_s = ST_HELD;
                        cnt_s   = 4'd0;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM state, candidate key and debounce counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cand_r  <= 4'd0;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cand_r  <= cand_s;
            cnt_r   <= cnt_s;
        end
    end

    // On an accept the incoming frame code always equals the candidate.
    assign accept      = accept_s;
    assign accept_code = frame_code;

endmodule

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner: one-cold column scan, row synchronizer, per-frame
// key classification, debounce, and a shift register of entered digits.
module hex_keypad_entry
    import keypad_pkg::*;
#(
    parameter int N        = 32,
    parameter int SCAN_DIV = 100000,
    parameter int DEBOUNCE = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   rows,
    input  logic         clear,
    output logic [3:0]   cols,
    output logic [N-1:0] value,
    output logic [3:0]   key_code,
    output logic         key_valid,
    output logic [3:0]   digit_count
);

    localparam int         DIV_W      = $clog2(SCAN_DIV);
    localparam logic [3:0] MAX_DIGITS = 4'(N / 4);

    logic [3:0]       rows_meta_r;
    logic [3:0]       rows_sync_r;
    logic [DIV_W-1:0] div_r;
    logic [1:0]       col_idx_r;
    logic [3:0]       cols_r;
    logic [1:0]       acc_hits_r;
    logic [3:0]       acc_code_r;
    logic [N-1:0]     value_r;
    logic [3:0]       key_code_r;
    logic             key_valid_r;
    logic [3:0]       digit_count_r;

    logic             col_end_s;
    logic             frame_end_s;
    logic [2:0]       col_hits_s;
    logic [3:0]       col_code_s;
    logic [2:0]       hit_sum_s;
    logic [1:0]       hits_sat_s;
    logic [3:0]       code_s;
    frame_t           frame_kind_s;
    logic             accept_s;
    logic [3:0]       accept_code_s;

    assign col_end_s   = (div_r == DIV_W'(SCAN_DIV - 1));
    assign frame_end_s = col_end_s && (col_idx_r == 2'd3);
    assign col_hits_s  = low_count(rows_sync_r);
    assign col_code_s  = key_map(first_low(rows_sync_r), col_idx_r);
    assign hit_sum_s   = {1'b0, acc_hits_r} + col_hits_s;

    // Merge this column's sample into the frame tally; 2 stands for "two or more".
    always_comb begin
        hits_sat_s   = 2'd0;
        code_s       = acc_code_r;
        frame_kind_s = FR_NONE;
        if (hit_sum_s >= 3'd2) begin
            hits_sat_s = 2'd2;
        end else begin
            hits_sat_s = hit_sum_s[1:0];
        end
        if (acc_hits_r == 2'd0) begin
            code_s = col_code_s;
        end else begin
            code_s = acc_code_r;
        end
        case (hits_sat_s)
            2'd0:    frame_kind_s = FR_NONE;
            2'd1:    frame_kind_s = FR_SINGLE;
            default: frame_kind_s = FR_MULTI;
        endcase
    end

    // Two-flop synchronizer for the asynchronous row lines (idle high).
    always_ff @(posedge clock) begin
        if (reset) begin
            rows_meta_r <= 4'b1111;
            rows_sync_r <= 4'b1111;
        end else begin
            rows_meta_r <= rows;
            rows_sync_r <= rows_meta_r;
        end
    end

    // Column period divider and one-cold column drive.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_r     <= '0;
            col_idx_r <= 2'd0;
            cols_r    <= 4'b1110;
        end else if (col_end_s) begin
            div_r     <= '0;
            col_idx_r <= col_idx_r + 2'd1;
            cols_r    <= ~(4'b0001 << (col_idx_r + 2'd1));
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Per-frame accumulation of pressed intersections across columns 0..2.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_hits_r <= 2'd0;
            acc_code_r <= 4'd0;
        end else if (frame_end_s) begin
            acc_hits_r <= 2'd0;
            acc_code_r <= 4'd0;
        end else if (col_end_s) begin
            acc_hits_r <= hits_sat_s;
            acc_code_r <= code_s;
        end else begin
            acc_hits_r <= acc_hits_r;
            acc_code_r <= acc_code_r;
        end
    end

    keypad_debouncer #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debouncer (
        .clock       (clock),
        .reset       (reset),
        .frame_valid (frame_end_s),
        .frame_kind  (frame_kind_s),
        .frame_code  (code_s),
        .accept      (accept_s),
        .accept_code (accept_code_s)
    );

    // Accept pulse and last key code; clear leaves these untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_valid_r <= 1'b0;
            key_code_r  <= 4'd0;
        end else begin
            key_valid_r <= accept_s;
            if (accept_s) begin
                key_code_r <= accept_code_s;
            end else begin
                key_code_r <= key_code_r;
            end
        end
    end

    // Digit shift register and saturating digit count; clear beats an accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            value_r       <= '0;
            digit_count_r <= 4'd0;
        end else if (clear) begin
            value_r       <= '0;
            digit_count_r <= 4'd0;
        end else if (accept_s) begin
            value_r <= (value_r << 3'd4) | N'(accept_code_s);
            if (digit_count_r < MAX_DIGITS) begin
                digit_count_r <= digit_count_r + 4'd1;
            end else begin
                digit_count_r <= digit_count_r;
            end
        end else begin
            value_r       <= value_r;
            digit_count_r <= digit_count_r;
        end
    end

    assign cols        = cols_r;
    assign value       = value_r;
    assign key_code    = key_code_r;
    assign key_valid   = key_valid_r;
    assign digit_count = digit_count_r;

endmodule
